// File: rtl/fetch_stage.sv
// fetch_stage: PC register, same-cycle imem handshake and IF/ID pipeline register
module fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   branch_taken_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  input  logic                   jump_i,
  input  logic [PC_WIDTH-1:0]    jump_target_i,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic                   imem_ready_i,
  output logic                   if_id_valid_o,
  output logic [INSTR_WIDTH-1:0] if_id_instr_o,
  output logic [5:0]             if_id_opcode_o,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4_o,
  output logic                   fetch_err_o
);
  typedef enum logic [1:0] {IDLE, FETCH, REDIRECT, ERR} state_t;
  state_t state;
  logic [PC_WIDTH-1:0] pc, target, pc_next4;
  logic stalled, transfer, redirect, misaligned;
  // Handshake, stall and redirect decode; req is combinational so a stall drops it in the same cycle
  always_comb begin
    stalled    = if_id_valid_o && stall_i;
    imem_req_o = (state == FETCH) && !stalled;
    transfer   = imem_req_o && imem_ready_i;
    redirect   = ((state == FETCH) || (state == REDIRECT)) && (jump_i || branch_taken_i);
    target     = jump_i ? jump_target_i : branch_target_i;
    misaligned = |target[1:0];
    pc_next4   = pc + PC_WIDTH'(4);
  end
  assign imem_addr_o    = pc;
  assign if_id_opcode_o = if_id_instr_o[31:26];
  // Fetch FSM together with the PC and IF/ID registers; a redirect beats stall and any same-cycle transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      if_id_valid_o    <= 1'b0;
      if_id_instr_o    <= '0;
      if_id_pc_plus4_o <= '0;
      fetch_err_o      <= 1'b0;
    end else if (redirect) begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= '0;
      if (misaligned) begin
        fetch_err_o <= 1'b1;
        state       <= ERR;
      end else begin
        pc    <= target;
        state <= REDIRECT;
      end
    end else if (state == FETCH) begin
      if (transfer) begin
        if_id_instr_o    <= imem_rdata_i;
        if_id_pc_plus4_o <= pc_next4;
        if_id_valid_o    <= 1'b1;
        pc               <= pc_next4;
      end else if (!stalled) begin
        if_id_valid_o <= 1'b0;
        if_id_instr_o <= '0;
      end
    end else if (state != ERR) begin
      state <= FETCH;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural fetch model
module tb_fetch_stage;
  localparam int WAIT = 0, RUN = 1, GAP = 2, DEAD = 3;
  logic clk = 0, rst_n = 0, stall = 0, br = 0, jmp = 0, ready = 0, hash = 0, checking = 0;
  logic [31:0] bt = 0, jt = 0, rdata, addr, instr, p4, addr2, instr2, p42, t, rt;
  logic [5:0] opc, opc2;
  logic req, valid, err, req2, valid2, err2, q;
  int total = 0, bad = 0, phase = 0, mode = WAIT, mcyc = 0;
  logic [31:0] mpc = 0, minstr = 0, mp4 = 0;
  logic mvalid = 0, merr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a, input logic h);
    return h ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) : a;
  endfunction

  assign rdata = mem(addr, hash);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(bt), .jump_i(jmp), .jump_target_i(jt),
    .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata), .imem_ready_i(ready),
    .if_id_valid_o(valid), .if_id_instr_o(instr), .if_id_opcode_o(opc),
    .if_id_pc_plus4_o(p4), .fetch_err_o(err)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(1'b0),
    .branch_taken_i(1'b0), .branch_target_i(32'h0), .jump_i(1'b0), .jump_target_i(32'h0),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(addr2), .imem_ready_i(1'b1),
    .if_id_valid_o(valid2), .if_id_instr_o(instr2), .if_id_opcode_o(opc2),
    .if_id_pc_plus4_o(p42), .fetch_err_o(err2)
  );

  function automatic logic mreq();
    return (mode == RUN) && !(mvalid && stall);
  endfunction

  // reference: what the fetch stage must hold after each clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = WAIT; mpc = 0; mvalid = 0; minstr = 0; mp4 = 0; merr = 0; mcyc = 0;
    end else begin
      mcyc++;
      q = mreq();
      t = jmp ? jt : bt;
      if ((mode == RUN || mode == GAP) && (jmp || br)) begin
        mvalid = 0; minstr = 0;
        if (t % 4 != 0) begin merr = 1; mode = DEAD; end
        else begin mpc = t; mode = GAP; end
      end else if (mode == RUN) begin
        if (q && ready) begin
          minstr = mem(mpc, hash); mp4 = mpc + 4; mvalid = 1; mpc = mpc + 4;
        end else if (q) begin
          mvalid = 0; minstr = 0;
        end
      end else if (mode != DEAD) mode = RUN;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // single compare process, sampled mid-cycle
  always @(negedge clk) if (checking) begin
    chk("req", {31'b0, req}, {31'b0, mreq()});
    chk("addr", addr, mpc);
    chk("valid", {31'b0, valid}, {31'b0, mvalid});
    chk("instr", instr, minstr);
    chk("opcode", {26'b0, opc}, {26'b0, minstr[31:26]});
    chk("pc_plus4", p4, mp4);
    chk("fetch_err", {31'b0, err}, {31'b0, merr});
    if (phase == 1) begin
      if (mcyc == 0) chk("lit_req_idle", {31'b0, req}, 32'd0);
      if (mcyc == 1) begin chk("lit_req_first", {31'b0, req}, 32'd1); chk("lit_addr_first", addr, 32'h0); end
      if (mcyc == 2) begin chk("lit_instr0", instr, 32'h0); chk("lit_p4_0", p4, 32'h4); chk("lit_valid", {31'b0, valid}, 32'd1); chk("lit_model0", mp4, 32'h4); end
      if (mcyc == 3) begin chk("lit_instr1", instr, 32'h4); chk("lit_p4_1", p4, 32'h8); chk("lit_model1", minstr, 32'h4); end
      if (mcyc == 4) begin chk("lit_instr2", instr, 32'h8); chk("lit_p4_2", p4, 32'hC); chk("lit_model2", mpc, 32'hC); end
    end
    if (rst_n && mcyc == 1) chk("wrap_addr_first", addr2, 32'hFFFF_FFFC);
    if (rst_n && mcyc == 2) begin chk("wrap_instr_first", instr2, 32'hFFFF_FFFC); chk("wrap_p4_first", p42, 32'h0); chk("wrap_addr_next", addr2, 32'h0); end
    if (rst_n && mcyc == 3) begin chk("wrap_instr_next", instr2, 32'h0); chk("wrap_p4_next", p42, 32'h4); chk("wrap_err", {31'b0, err2}, 32'd0); end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    checking = 1;
    #1 rst_n = 1; ready = 1; phase = 1;
    step(5);
    phase = 2;
    ready = 0; step(3); ready = 1; step(2);
    stall = 1; step(2); stall = 0; step(2);
    jt = 32'h200; bt = 32'h100; jmp = 1; br = 1; step(1); jmp = 0; br = 0; step(3);
    br = 1; step(1); br = 0; step(3);
    br = 1; step(1); bt = 32'h300; step(1); br = 0; step(3);
    stall = 1; br = 1; bt = 32'h40; step(1); br = 0; step(2); stall = 0; step(2);
    jt = 32'h102; jmp = 1; step(1); jmp = 0; step(5);
    rst_n = 0; step(1); rst_n = 1; step(4);
    #1 rst_n = 0; step(1); rst_n = 1; step(3);
    hash = 1;
    for (int i = 0; i < 4000; i++) begin
      rst_n = !(i % 250 == 249 || (merr && $urandom_range(0, 7) == 0));
      ready = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 4) == 0;
      rt = $urandom_range(0, 19);
      jmp = rt == 0;
      br = rt <= 1 || rt == 5;
      t = $urandom;
      jt = ($urandom_range(0, 9) == 0) ? t : (t & ~32'h3);
      t = $urandom;
      bt = ($urandom_range(0, 9) == 0) ? t : (t & ~32'h3);
      step(1);
    end
    @(negedge clk);
    #1 checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
